rvvidepacketizer: RTL and testbench
===================================

// Module: rvvidepacketizer
// PURPOSE
//  Receive end of the RVVI-over-Ethernet trace link. Consumes 32-bit AXI-Stream frames from an Ethernet MAC RX FIFO.
//  Checks the MAC/ethertype header, reassembles one RVVI trace record per frame and presents it on a valid/ready port.
//  Used in loopback benches and in checker FPGAs that consume the trace stream.
// PARAMETERS
//  RVVI_WIDTH  792            bits per record (72+5*XLEN+MAX_CSRS*(XLEN+16), XLEN=64, MAX_CSRS=5)
//  DST_MAC     48'h4502_1111_6843  accepted destination MAC
//  ETH_TYPE    16'h005c       accepted ethertype
//  MAC_FILTER  1              1: drop frames whose dst MAC != DST_MAC; 0: accept any dst
// PORTS
//  m_axi_aclk     in   1           sole clock
//  m_axi_aresetn  in   1           async assert, active-low reset
//  RvviAxiRdata   in   32          AXIS tdata
//  RvviAxiRstrb   in   4           AXIS tkeep (ignored, full words assumed)
//  RvviAxiRvalid  in   1           AXIS tvalid
//  RvviAxiRlast   in   1           AXIS tlast
//  RvviAxiRready  out  1           AXIS tready
//  rvvi           out  RVVI_WIDTH  reassembled record
//  valid          out  1           record available
//  ready          in   1           consumer accepts record
//  FrameCnt       out  16          records delivered, saturating
//  DropCnt        out  16          frames filtered (MAC/ethertype), saturating
//  ErrCnt         out  16          malformed frames (short/long), saturating
//  SeqErr         out  1           1-cycle pulse on sequence gap (see CONFIGURATION)
// BEHAVIOUR
//  Frame layout (beats): b0=dst[31:0]; b1={src[15:0],dst[47:32]}; b2=src[47:16]; b3={seq[15:0],ethertype}.
//  Payload follows as NW=ceil(RVVI_WIDTH/32) beats, LSB first; unused upper bits of the last beat are ignored.
//  The last payload beat carries tlast.
//  Beat accepted when RvviAxiRvalid&RvviAxiRready. RvviAxiRready=1 in all states except HOLD.
//  FSM states: HDR0..HDR3, PAY, DROP, HOLD. Reset state is HDR0.
//  HDR0-HDR2: compare MAC fields when MAC_FILTER=1.
//   Mismatch -> DROP, DropCnt++, unless tlast is on this beat -> HDR0.
//   tlast on any header beat -> HDR0, ErrCnt++.
//  HDR3: ethertype != ETH_TYPE -> DROP, DropCnt++. Else -> PAY, beat index=0.
//  PAY: shift beat into the staging register at word index idx.
//   tlast with idx<NW-1 -> HDR0, ErrCnt++ (short frame).
//   idx==NW-1 without tlast -> DROP, ErrCnt++ (long frame).
//   idx==NW-1 with tlast -> copy staging to rvvi, valid=1, FrameCnt++.
//    Next state is HOLD if the previous record is still pending, else HDR0.
//  DROP: discard beats; on tlast -> HDR0.
//  Output handshake: valid stays high with rvvi stable until valid&ready. On that cycle valid falls unless a new record loads the same cycle.
//  HOLD: staging holds a complete record while valid&~ready. tready=0. On ready: transfer staging, valid stays 1 -> HDR0.
//  Latency: valid rises the cycle after the final payload beat handshake.
//  Counters saturate at 16'hFFFF, no wrap. The beat index is 5 bits minimum, sized $clog2(NW)+1.
//  Reset: state=HDR0, valid=0, rvvi=0, staging=0, counters=0, SeqErr=0, RvviAxiRready=0 during reset, 1 after.
//  Reset mid-frame: the partial frame is lost; the remainder of that frame is parsed as a new header.
//   That remainder normally fails the filter and is dropped.
// CONFIGURATION
//  RVVI_SEQ_CHECK_EN defined:
//   Hold last accepted seq. On each frame delivered, if seq != last+1 (mod 2^16) and not the first frame since reset, pulse SeqErr.
//   Update last=seq.
//  RVVI_SEQ_CHECK_EN undefined: seq field ignored, SeqErr tied 0, no seq registers.
// TESTING
//  1. Good frame, payload words k = 32'hA000_0000+k -> rvvi[31:0]=A0000000, rvvi[791:768]=24'h000018.
//     valid 1 cycle after last beat; FrameCnt=1.
//  2. b3 ethertype 16'h0800, 29 beats -> no valid; DropCnt=1; the following good frame is delivered intact.
//  3. Short frame, tlast on payload beat 10 -> ErrCnt=1, valid stays 0.
//     Long frame, 30 beats -> ErrCnt=2; the next good frame is delivered.
//  4. ready=0 and two back-to-back good frames -> first record held; tready drops after the second frame's last beat.
//     ready=1 -> both records delivered in order, FrameCnt=2.
//  5. m_axi_aresetn low at payload beat 12, then released -> all outputs 0.
//     Remaining beats dropped (DropCnt=1); the next good frame is delivered.
//  6. [RVVI_SEQ_CHECK_EN] seqs 1,2,4 -> single SeqErr pulse on third delivery. Without the macro, SeqErr remains 0.

Source files
------------

// File: rtl/rvvidepacketizer.sv
// RVVI-over-Ethernet receive depacketizer: filters MAC/ethertype header and reassembles one trace record per frame.
// Optional sequence-gap detection is enabled by defining RVVI_SEQ_CHECK_EN.
//
// state | meaning
// HDR0  | expect dst[31:0]
// HDR1  | expect {src[15:0], dst[47:32]}
// HDR2  | expect src[47:16]
// HDR3  | expect {seq, ethertype}
// PAY   | collecting payload words into staging
// DROP  | discarding beats until tlast
// HOLD  | complete record parked in staging while the output is still occupied
module rvvidepacketizer #(
    parameter int          RVVI_WIDTH = 792,
    parameter logic [47:0] DST_MAC    = 48'h4502_1111_6843,
    parameter logic [15:0] ETH_TYPE   = 16'h005c,
    parameter bit          MAC_FILTER = 1'b1
) (
    input  logic                  m_axi_aclk,
    input  logic                  m_axi_aresetn,
    input  logic [31:0]           RvviAxiRdata,
    input  logic [3:0]            RvviAxiRstrb,
    input  logic                  RvviAxiRvalid,
    input  logic                  RvviAxiRlast,
    output logic                  RvviAxiRready,
    output logic [RVVI_WIDTH-1:0] rvvi,
    output logic                  valid,
    input  logic                  ready,
    output logic [15:0]           FrameCnt,
    output logic [15:0]           DropCnt,
    output logic [15:0]           ErrCnt,
    output logic                  SeqErr
);
    localparam int NW    = (RVVI_WIDTH + 31) / 32;
    localparam int IDX_W = ($clog2(NW) + 1 < 5) ? 5 : $clog2(NW) + 1;

    typedef enum logic [2:0] {S_HDR0, S_HDR1, S_HDR2, S_HDR3, S_PAY, S_DROP, S_HOLD} state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx;
    logic [NW*32-1:0]   staging, staging_nxt;
    logic               out_en;
    logic               beat;
    logic               load, hold_xfer, stage_we, idx_clr, idx_inc, seq_cap;
    logic               inc_frame, inc_drop, inc_err;
    logic               unused_bits;

    // tkeep is ignored: full words are assumed. The staging pad above RVVI_WIDTH never reaches rvvi.
    assign unused_bits   = ^{RvviAxiRstrb, staging[NW*32-1 -: 32]};
    assign RvviAxiRready = out_en && (state != S_HOLD);
    assign beat          = RvviAxiRvalid && RvviAxiRready;

    always_comb begin
        staging_nxt = staging;
        for (int w = 0; w < NW; w++)
            if (idx == IDX_W'(w)) staging_nxt[w*32 +: 32] = RvviAxiRdata;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        hold_xfer = 1'b0;
        stage_we  = 1'b0;
        idx_clr   = 1'b0;
        idx_inc   = 1'b0;
        seq_cap   = 1'b0;
        inc_frame = 1'b0;
        inc_drop  = 1'b0;
        inc_err   = 1'b0;
        case (state)
            S_HDR0, S_HDR1, S_HDR2: if (beat) begin
                if (RvviAxiRlast) begin
                    state_nxt = S_HDR0;
                    inc_err   = 1'b1;
                end else if (MAC_FILTER &&
                             ((state == S_HDR0 && RvviAxiRdata != DST_MAC[31:0]) ||
                              (state == S_HDR1 && RvviAxiRdata[15:0] != DST_MAC[47:32]))) begin
                    state_nxt = S_DROP;
                    inc_drop  = 1'b1;
                end else begin
                    state_nxt = (state == S_HDR0) ? S_HDR1 : (state == S_HDR1) ? S_HDR2 : S_HDR3;
                end
            end
            S_HDR3: if (beat) begin
                if (RvviAxiRlast) begin
                    state_nxt = S_HDR0;
                    inc_err   = 1'b1;
                end else if (RvviAxiRdata[15:0] != ETH_TYPE) begin
                    state_nxt = S_DROP;
                    inc_drop  = 1'b1;
                end else begin
                    state_nxt = S_PAY;
                    idx_clr   = 1'b1;
                    seq_cap   = 1'b1;
                end
            end
            S_PAY: if (beat) begin
                stage_we = 1'b1;
                if (idx == IDX_W'(NW - 1)) begin
                    if (RvviAxiRlast) begin
                        inc_frame = 1'b1;
                        if (valid && !ready) begin
                            state_nxt = S_HOLD;
                        end else begin
                            load      = 1'b1;
                            state_nxt = S_HDR0;
                        end
                    end else begin
                        state_nxt = S_DROP;
                        inc_err   = 1'b1;
                    end
                end else if (RvviAxiRlast) begin
                    state_nxt = S_HDR0;
                    inc_err   = 1'b1;
                end else begin
                    idx_inc = 1'b1;
                end
            end
            S_DROP: if (beat && RvviAxiRlast) state_nxt = S_HDR0;
            S_HOLD: if (ready) begin
                hold_xfer = 1'b1;
                state_nxt = S_HDR0;
            end
            default: state_nxt = S_HDR0;
        endcase
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state    <= S_HDR0;
            out_en   <= 1'b0;
            idx      <= '0;
            staging  <= '0;
            rvvi     <= '0;
            valid    <= 1'b0;
            FrameCnt <= '0;
            DropCnt  <= '0;
            ErrCnt   <= '0;
        end else begin
            state  <= state_nxt;
            out_en <= 1'b1;
            if (idx_clr)      idx <= '0;
            else if (idx_inc) idx <= idx + 1'b1;
            if (stage_we) staging <= staging_nxt;
            if (load)           rvvi <= staging_nxt[RVVI_WIDTH-1:0];
            else if (hold_xfer) rvvi <= staging[RVVI_WIDTH-1:0];
            if (load || hold_xfer) valid <= 1'b1;
            else if (ready)        valid <= 1'b0;
            if (inc_frame && FrameCnt != 16'hFFFF) FrameCnt <= FrameCnt + 16'd1;
            if (inc_drop && DropCnt != 16'hFFFF)   DropCnt  <= DropCnt + 16'd1;
            if (inc_err && ErrCnt != 16'hFFFF)     ErrCnt   <= ErrCnt + 16'd1;
        end
    end

`ifdef RVVI_SEQ_CHECK_EN
    logic [15:0] seq_cur, seq_last;
    logic        seq_seen;

    // Compared at frame completion; the first frame after reset only seeds seq_last.
    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            seq_cur  <= '0;
            seq_last <= '0;
            seq_seen <= 1'b0;
            SeqErr   <= 1'b0;
        end else begin
            SeqErr <= 1'b0;
            if (seq_cap) seq_cur <= RvviAxiRdata[31:16];
            if (inc_frame) begin
                if (seq_seen && seq_cur != seq_last + 16'd1) SeqErr <= 1'b1;
                seq_last <= seq_cur;
                seq_seen <= 1'b1;
            end
        end
    end
`else
    logic unused_seq;
    assign unused_seq = seq_cap;
    assign SeqErr     = 1'b0;
`endif

endmodule

// File: tb/tb_rvvidepacketizer.sv
// Directed bench for rvvidepacketizer: header filtering, reassembly, malformed frames, output hold, reset mid-frame.
// Sequence-gap expectations follow RVVI_SEQ_CHECK_EN when defined.
module tb_rvvidepacketizer;
    localparam logic [47:0] DST = 48'h4502_1111_6843;
    localparam logic [47:0] SRC = 48'h0011_2233_4455;
`ifdef RVVI_SEQ_CHECK_EN
    localparam logic SEQ_EXP = 1'b1;
`else
    localparam logic SEQ_EXP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  tdata = '0;
    logic [3:0]   tkeep = 4'hF;
    logic         tvalid = 1'b0;
    logic         tlast = 1'b0;
    logic         tready;
    logic [791:0] rvvi;
    logic         rvalid;
    logic         rready = 1'b0;
    logic [15:0]  frame_cnt, drop_cnt, err_cnt;
    logic         seq_err;

    int vectors = 0;
    int miscompares = 0;
    int seq_pulses = 0;
    int p0;

    always #5 clk = ~clk;

    rvvidepacketizer dut (
        .m_axi_aclk   (clk),
        .m_axi_aresetn(rst_n),
        .RvviAxiRdata (tdata),
        .RvviAxiRstrb (tkeep),
        .RvviAxiRvalid(tvalid),
        .RvviAxiRlast (tlast),
        .RvviAxiRready(tready),
        .rvvi         (rvvi),
        .valid        (rvalid),
        .ready        (rready),
        .FrameCnt     (frame_cnt),
        .DropCnt      (drop_cnt),
        .ErrCnt       (err_cnt),
        .SeqErr       (seq_err)
    );

    always @(negedge clk) if (seq_err === 1'b1) seq_pulses++;

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [791:0] exp_rec(input logic [31:0] base);
        logic [799:0] t;
        for (int k = 0; k < 25; k++) t[k*32 +: 32] = base + 32'(k);
        return t[791:0];
    endfunction

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send_beat(input logic [31:0] d, input logic l);
        int n;
        n = 0;
        tdata  = d;
        tlast  = l;
        tvalid = 1'b1;
        while (tready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check_vec("tready_timeout", 64'(tready), 64'd1);
        @(negedge clk);
    endtask

    task automatic send_hdr(input logic [47:0] dst, input logic [15:0] seq, input logic [15:0] etype);
        send_beat(dst[31:0], 1'b0);
        send_beat({SRC[15:0], dst[47:32]}, 1'b0);
        send_beat(SRC[47:16], 1'b0);
        send_beat({seq, etype}, 1'b0);
    endtask

    task automatic send_frame(input logic [47:0] dst, input logic [15:0] seq, input logic [15:0] etype,
                              input logic [31:0] base, input int npay);
        send_hdr(dst, seq, etype);
        for (int k = 0; k < npay; k++) send_beat(base + 32'(k), (k == npay - 1));
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic consume();
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tvalid = 1'b0;
        tlast  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        @(negedge clk);
        check_vec("rst_tready", 64'(tready), 64'd0);
        check_vec("rst_valid", 64'(rvalid), 64'd0);
        check_vec("rst_rvvi_lo", rvvi[63:0], 64'd0);
        check_vec("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        check_vec("rst_seqerr", 64'(seq_err), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_vec("post_rst_tready", 64'(tready), 64'd1);

        // good frame, latency and content
        check_vec("t1_valid_before", 64'(rvalid), 64'd0);
        send_frame(DST, 16'd1, 16'h005c, 32'hA000_0000, 25);
        check_vec("t1_valid", 64'(rvalid), 64'd1);
        check_vec("t1_word0", 64'(rvvi[31:0]), 64'hA000_0000);
        check_vec("t1_top", 64'(rvvi[791:768]), 64'h00_0018);
        check_vec("t1_rec", 64'(rvvi === exp_rec(32'hA000_0000)), 64'd1);
        check_vec("t1_frame_cnt", 64'(frame_cnt), 64'd1);
        consume();
        check_vec("t1_valid_after", 64'(rvalid), 64'd0);

        // wrong ethertype, then wrong dst MAC, each followed by a good frame
        send_frame(DST, 16'd2, 16'h0800, 32'hC000_0000, 25);
        check_vec("t2_valid", 64'(rvalid), 64'd0);
        check_vec("t2_drop_cnt", 64'(drop_cnt), 64'd1);
        send_frame(DST, 16'd2, 16'h005c, 32'hB000_0000, 25);
        check_vec("t2_rec", 64'(rvvi === exp_rec(32'hB000_0000)), 64'd1);
        check_vec("t2_frame_cnt", 64'(frame_cnt), 64'd2);
        consume();
        send_frame(48'h1234_5678_9ABC, 16'd3, 16'h005c, 32'hC100_0000, 25);
        check_vec("t2_mac_valid", 64'(rvalid), 64'd0);
        check_vec("t2_mac_drop_cnt", 64'(drop_cnt), 64'd2);
        send_frame(DST, 16'd3, 16'h005c, 32'hB100_0000, 25);
        check_vec("t2_mac_rec", 64'(rvvi === exp_rec(32'hB100_0000)), 64'd1);
        consume();

        // short and long frames
        send_frame(DST, 16'd4, 16'h005c, 32'hD000_0000, 11);
        check_vec("t3_short_err", 64'(err_cnt), 64'd1);
        check_vec("t3_short_valid", 64'(rvalid), 64'd0);
        send_frame(DST, 16'd4, 16'h005c, 32'hD100_0000, 26);
        check_vec("t3_long_err", 64'(err_cnt), 64'd2);
        check_vec("t3_long_valid", 64'(rvalid), 64'd0);
        send_frame(DST, 16'd4, 16'h005c, 32'hE000_0000, 25);
        check_vec("t3_rec", 64'(rvvi === exp_rec(32'hE000_0000)), 64'd1);
        check_vec("t3_frame_cnt", 64'(frame_cnt), 64'd4);
        consume();

        // back-to-back records with the consumer stalled
        send_frame(DST, 16'd5, 16'h005c, 32'h1000_0000, 25);
        check_vec("t4_first_valid", 64'(rvalid), 64'd1);
        send_frame(DST, 16'd6, 16'h005c, 32'h2000_0000, 25);
        check_vec("t4_hold_tready", 64'(tready), 64'd0);
        check_vec("t4_hold_valid", 64'(rvalid), 64'd1);
        check_vec("t4_hold_word0", 64'(rvvi[31:0]), 64'h1000_0000);
        check_vec("t4_first_rec", 64'(rvvi === exp_rec(32'h1000_0000)), 64'd1);
        check_vec("t4_frame_cnt", 64'(frame_cnt), 64'd6);
        rready = 1'b1;
        @(negedge clk);
        check_vec("t4_second_valid", 64'(rvalid), 64'd1);
        check_vec("t4_second_rec", 64'(rvvi === exp_rec(32'h2000_0000)), 64'd1);
        check_vec("t4_tready_back", 64'(tready), 64'd1);
        @(negedge clk);
        check_vec("t4_drained", 64'(rvalid), 64'd0);
        rready = 1'b0;

        // reset in the middle of a payload
        send_hdr(DST, 16'd7, 16'h005c);
        for (int k = 0; k < 12; k++) send_beat(32'hA000_0000 + 32'(k), 1'b0);
        tvalid = 1'b0;
        rst_n  = 1'b0;
        @(negedge clk);
        check_vec("t5_rst_valid", 64'(rvalid), 64'd0);
        check_vec("t5_rst_rvvi", 64'(rvvi === 792'd0), 64'd1);
        check_vec("t5_rst_counts", {16'd0, frame_cnt, drop_cnt, err_cnt}, 64'd0);
        check_vec("t5_rst_tready", 64'(tready), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int k = 12; k < 25; k++) send_beat(32'hA000_0000 + 32'(k), (k == 24));
        tvalid = 1'b0;
        tlast  = 1'b0;
        check_vec("t5_drop_cnt", 64'(drop_cnt), 64'd1);
        check_vec("t5_err_cnt", 64'(err_cnt), 64'd0);
        check_vec("t5_no_valid", 64'(rvalid), 64'd0);
        send_frame(DST, 16'd8, 16'h005c, 32'h3000_0000, 25);
        check_vec("t5_rec", 64'(rvvi === exp_rec(32'h3000_0000)), 64'd1);
        check_vec("t5_frame_cnt", 64'(frame_cnt), 64'd1);
        consume();

        // sequence gap 1,2,4
        do_reset();
        p0 = seq_pulses;
        send_frame(DST, 16'd1, 16'h005c, 32'h4000_0000, 25);
        check_vec("t6_seqerr1", 64'(seq_err), 64'd0);
        consume();
        send_frame(DST, 16'd2, 16'h005c, 32'h5000_0000, 25);
        check_vec("t6_seqerr2", 64'(seq_err), 64'd0);
        consume();
        send_frame(DST, 16'd4, 16'h005c, 32'h6000_0000, 25);
        check_vec("t6_seqerr3", 64'(seq_err), 64'(SEQ_EXP));
        check_vec("t6_rec", 64'(rvvi === exp_rec(32'h6000_0000)), 64'd1);
        consume();
        @(negedge clk);
        check_vec("t6_pulses", 64'(seq_pulses - p0), 64'(SEQ_EXP));
        check_vec("t6_frame_cnt", 64'(frame_cnt), 64'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
